// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake, operand and writeback signals between the issue
// stage (slave) and its environment (master: decoder, ALU, writeback consumer).
interface alu_issue_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [AW-1:0] in_rd;
    logic [AW-1:0] in_rs;
    logic [AW-1:0] in_rt;
    logic [DW-1:0] in_imm;
    logic          in_use_imm;
    logic          hold;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_y;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;

    modport master (
        output in_valid, in_op, in_rd, in_rs, in_rt, in_imm, in_use_imm, hold, alu_y,
        input  in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs, in_rt, in_imm, in_use_imm, hold, alu_y,
        output in_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue + writeback around the MIPSCORE16 ALU.
// Reads operands from an NREGS x DW register file, bypasses the completing
// result, registers a/b/op to the ALU and writes the ALU result back.
// Optional: define ALU_ISSUE_REG0_ZERO_EN to make r0 a hardwired zero.
module alu_issue_stage #(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_issue_if.slave bus
);
    localparam int AW = $clog2(NREGS);

    logic [DW-1:0] rf_q [NREGS];
    logic          ex_valid_q;
    logic [AW-1:0] ex_rd_q;
    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [2:0]    alu_op_q;
    logic          wb_valid_q;
    logic [AW-1:0] wb_rd_q;
    logic [DW-1:0] wb_data_q;

    logic          in_ready, accept, complete;
    logic          fwd_en, rf_we;
    logic [DW-1:0] rs_val, rt_val, fwd_a, fwd_b;

    // Handshake: the execute slot frees up whenever it is empty or retiring.
    always_comb begin
        in_ready = !ex_valid_q || !bus.hold;
        accept   = bus.in_valid && in_ready;
        complete = ex_valid_q && !bus.hold;
    end

    // Register read, bypass from the retiring instruction, and write enable.
`ifdef ALU_ISSUE_REG0_ZERO_EN
    always_comb begin
        rs_val = (bus.in_rs == '0) ? '0 : rf_q[bus.in_rs];
        rt_val = (bus.in_rt == '0) ? '0 : rf_q[bus.in_rt];
        fwd_en = complete && (ex_rd_q != '0);
        rf_we  = complete && (ex_rd_q != '0);
    end
`else
    always_comb begin
        rs_val = rf_q[bus.in_rs];
        rt_val = rf_q[bus.in_rt];
        fwd_en = complete;
        rf_we  = complete;
    end
`endif

    // Bypassed alu_y wins over the stale register-file copy.
    always_comb begin
        fwd_a = (fwd_en && ex_rd_q == bus.in_rs) ? bus.alu_y : rs_val;
        fwd_b = (fwd_en && ex_rd_q == bus.in_rt) ? bus.alu_y : rt_val;
        if (bus.in_use_imm) fwd_b = bus.in_imm;
    end

    // Register file: only the retiring destination is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[ex_rd_q] <= bus.alu_y;
        end
    end

    // Execute slot: loads on accept, empties on retire, frozen under hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rd_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
        end else if (accept) begin
            ex_valid_q <= 1'b1;
            ex_rd_q    <= bus.in_rd;
            alu_a_q    <= fwd_a;
            alu_b_q    <= fwd_b;
            alu_op_q   <= bus.in_op;
        end else if (complete) begin
            ex_valid_q <= 1'b0;
        end
    end

    // Writeback report: one-cycle pulse; rd/data keep the last retired value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            wb_valid_q <= complete;
            if (complete) begin
                wb_rd_q   <= ex_rd_q;
                wb_data_q <= bus.alu_y;
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_op   = alu_op_q;
    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: randomized + directed bench for alu_issue_stage.
// The reference model executes each instruction architecturally at accept
// time (in-order register array) and predicts the writeback stream.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;

    alu_issue_if #(.DW(16), .AW(3)) bus ();

    alu_issue_stage #(.NREGS(8), .DW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
    } item_t;

    logic [15:0] mrf [8];
    bit          m_ex, m_wbv;
    item_t       m_exi, m_wbi;

    function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a + 16'd1;
            3'd3: return a - 16'd1;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: begin p = a * b; return p[15:0]; end
        endcase
    endfunction

    // Combinational ALU the stage drives.
    always_comb bus.alu_y = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    function automatic logic [15:0] mread(input logic [2:0] r);
`ifdef ALU_ISSUE_REG0_ZERO_EN
        if (r == 3'd0) return 16'h0;
`endif
        return mrf[r];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
        m_ex  = 1'b0;
        m_wbv = 1'b0;
        m_exi = '{op: 3'd0, rd: 3'd0, a: 16'h0, b: 16'h0, res: 16'h0};
        m_wbi = m_exi;
    endtask

    // One clock: drive after the edge, check and advance the model mid-cycle.
    task automatic cyc(input bit v, input logic [2:0] op, input logic [2:0] rd,
                       input logic [2:0] rs, input logic [2:0] rt,
                       input logic [15:0] imm, input bit ui, input bit h);
        bit    exp_rdy, cmp, acc;
        item_t it;
        @(posedge clk);
        #1;
        bus.in_valid = v; bus.in_op = op; bus.in_rd = rd; bus.in_rs = rs;
        bus.in_rt = rt; bus.in_imm = imm; bus.in_use_imm = ui; bus.hold = h;
        @(negedge clk);
        exp_rdy = !m_ex || !h;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("wb_valid", 32'(bus.wb_valid), 32'(m_wbv));
        chk("wb_rd",    32'(bus.wb_rd),    32'(m_wbi.rd));
        chk("wb_data",  32'(bus.wb_data),  32'(m_wbi.res));
        chk("alu_a",    32'(bus.alu_a),    32'(m_exi.a));
        chk("alu_b",    32'(bus.alu_b),    32'(m_exi.b));
        chk("alu_op",   32'(bus.alu_op),   32'(m_exi.op));
        cmp = m_ex && !h;
        acc = v && exp_rdy;
        if (cmp) m_wbi = m_exi;
        m_wbv = cmp;
        if (acc) begin
            it.op  = op;
            it.rd  = rd;
            it.a   = mread(rs);
            it.b   = ui ? imm : mread(rt);
            it.res = alu_f(op, it.a, it.b);
            mrf[rd] = it.res;
            m_exi = it;
        end
        m_ex = acc || (m_ex && h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0);
    endtask

    // Async reset asserted just after an edge, with random inputs applied.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'($urandom); bus.in_op = 3'($urandom); bus.in_rd = 3'($urandom);
        bus.in_rs = 3'($urandom); bus.in_rt = 3'($urandom); bus.in_imm = 16'($urandom);
        bus.in_use_imm = 1'($urandom); bus.hold = 1'($urandom);
        #1;
        chk("rst_alu_a",    32'(bus.alu_a),    32'h0);
        chk("rst_alu_b",    32'(bus.alu_b),    32'h0);
        chk("rst_alu_op",   32'(bus.alu_op),   32'h0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
        chk("rst_wb_rd",    32'(bus.wb_rd),    32'h0);
        chk("rst_wb_data",  32'(bus.wb_data),  32'h0);
        bus.in_valid = 1'b0; bus.hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        model_clear();
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_rd = 3'd0; bus.in_rs = 3'd0;
        bus.in_rt = 3'd0; bus.in_imm = 16'h0; bus.in_use_imm = 1'b0; bus.hold = 1'b0;
        repeat (2) @(posedge clk);

        // 1: reset, then read every register back through OR-with-zero.
        do_reset();
        for (int r = 0; r < 8; r++) cyc(1'b1, 3'd5, 3'(r), 3'(r), 3'd0, 16'h0, 1'b1, 1'b0);
        idle(2);

        // 2: back-to-back dependency resolved through the bypass.
        cyc(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 16'd5, 1'b1, 1'b0);
        cyc(1'b1, 3'd0, 3'd2, 3'd1, 3'd0, 16'd3, 1'b1, 1'b0);
        idle(2);

        // 3: mul wraps to low 16 bits; sub underflows to 0xFFFF.
        cyc(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 16'h0100, 1'b1, 1'b0);
        cyc(1'b1, 3'd7, 3'd3, 3'd1, 3'd1, 16'h0, 1'b0, 1'b0);
        cyc(1'b1, 3'd1, 3'd4, 3'd0, 3'd0, 16'd1, 1'b1, 1'b0);
        idle(2);

        // 4: hold for three cycles with a new instruction waiting.
        cyc(1'b1, 3'd6, 3'd5, 3'd3, 3'd4, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'd2, 3'd6, 3'd5, 3'd0, 16'h0, 1'b0, 1'b1);
        idle(3);

        // 5: reset during the execute cycle drops the instruction.
        cyc(1'b1, 3'd0, 3'd5, 3'd0, 3'd0, 16'h1234, 1'b1, 1'b0);
        do_reset();
        cyc(1'b1, 3'd5, 3'd6, 3'd5, 3'd0, 16'h0, 1'b1, 1'b0);
        idle(2);

        // 6: r0 write then read, outcome depends on the r0-zero build option.
        cyc(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 16'd7, 1'b1, 1'b0);
        cyc(1'b1, 3'd0, 3'd1, 3'd0, 3'd0, 16'd0, 1'b1, 1'b0);
        idle(2);

        // Random traffic with random hold and valid gaps.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 99) < 80), 3'($urandom), 3'($urandom), 3'($urandom),
                3'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 99) < 25));
        idle(3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Cycle budget guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue and writeback stage that sits around the 16-bit combinational ALU in MIPSCORE16.
- Accepts decoded ALU instructions through a valid/ready handshake and reads operands from an 8x16 register file, with bypass from the completing instruction.
- Drives registered a/b/op to the ALU, then captures the ALU result and writes it back to the register file.
- Throughput is one instruction per cycle. Stalls come only from downstream hold.

Parameters:
- NREGS, 8, number of architectural registers; register index width is log2(NREGS) = 3.
- DW, 16, datapath width; must match the ALU width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_op  input  3  ALU opcode, passed through unchanged (000 add, 001 sub, 010 inc, 011 dec, 100 and, 101 or, 110 xor, 111 mul).
- in_rd  input  3  destination register.
- in_rs  input  3  source register for operand A.
- in_rt  input  3  source register for operand B.
- in_imm  input  16  immediate value.
- in_use_imm  input  1  1 = operand B comes from in_imm; 0 = operand B comes from rf[rt].
- hold  input  1  downstream stall; freezes the execute slot.
- alu_a  output  16  registered operand A to the ALU.
- alu_b  output  16  registered operand B to the ALU.
- alu_op  output  3  registered opcode to the ALU.
- alu_y  input  16  combinational ALU result.
- wb_valid  output  1  one-cycle pulse per retired instruction.
- wb_rd  output  3  destination of the retired instruction.
- wb_data  output  16  result of the retired instruction.

Behaviour:
- Reset (async, rst_n=0):
  - all register-file entries = 0;
  - ex_valid, ex_rd = 0;
  - alu_a, alu_b, alu_op = 0;
  - wb_valid, wb_rd, wb_data = 0;
  - in_ready = 1 once reset is released.
- Reset mid-operation drops any in-flight instruction; no writeback occurs.
- Ready: in_ready = !ex_valid || !hold (combinational). Accept = in_valid && in_ready.
- Complete: complete = ex_valid && !hold.
- On accept at clock edge N:
  - ex_valid <= 1; alu_op <= in_op; ex_rd <= in_rd;
  - alu_a <= fwd(in_rs);
  - alu_b <= in_use_imm ? in_imm : fwd(in_rt).
- Forwarding: fwd(r) = alu_y if (complete && ex_rd == r), else rf[r]. This covers back-to-back dependencies with no stall.
- On complete at edge N+1:
  - rf[ex_rd] <= alu_y;
  - wb_valid <= 1; wb_rd <= ex_rd; wb_data <= alu_y;
  - ex_valid <= accept (back-to-back issue allowed).
- When not completing: wb_valid <= 0; wb_rd and wb_data hold their last values.
- Latency: accept edge N → ALU inputs valid during cycle N+1 → wb_valid high and rf updated after edge N+1.
- Hold with ex_valid=1:
  - alu_a, alu_b, alu_op and ex_rd frozen;
  - in_ready = 0;
  - no rf write; wb_valid = 0.
- Hold with ex_valid=0: in_ready stays 1. Accepting loads the ex slot, which then waits for hold to release.
- Idle (no accept, no valid ex): alu_a, alu_b and alu_op retain their last values; ex_valid = 0.
- Arithmetic is the ALU's responsibility: 16-bit modulo results, mul returns the low 16 bits. This stage neither widens nor checks results.
- Simultaneous rf write and read of the same register: the forwarded alu_y wins.
- Writes to distinct registers never disturb other entries.

Optional Feature:
- Macro: ALU_ISSUE_REG0_ZERO_EN.
- Defined:
  - r0 always reads 0;
  - writes to r0 are discarded;
  - forwarding is suppressed when ex_rd == 0;
  - wb_valid, wb_rd and wb_data still report the retired result.
- Undefined: r0 is an ordinary writable register, identical to r1..r7.

Test Plan:
1. Assert rst_n=0 with random inputs → all outputs 0, wb_valid=0. After release, in_ready=1 and every rf entry reads 0.
2. Issue ADD rd=1 rs=0 imm=5, then next cycle ADD rd=2 rs=1 imm=3 back-to-back → alu_a=5 via forward on the second instruction; wb pulses (1,0x0005) then (2,0x0008) on consecutive cycles.
3. With r1=0x0100, issue MUL rd=3 rs=1 rt=1 → wb_data=0x0000. Then SUB rd=4 rs=0 imm=1 → wb_data=0xFFFF.
4. Issue an instruction, then hold=1 for 3 cycles → alu_a/alu_b/alu_op stable, in_ready=0, wb_valid=0 throughout. On release, exactly one wb pulse with the correct value.
5. Issue an instruction, then pull rst_n low during the execute cycle → no wb pulse, target rf entry remains 0, in_ready=1 after release.
6. Built with ALU_ISSUE_REG0_ZERO_EN: ADD rd=0 rs=0 imm=7, then ADD rd=1 rs=0 imm=0 → first wb_data=7; second wb_data=0 (r0 not written, no forward). Built without the macro: second wb_data=7.
